// File: rtl/fifo_pkg.sv
// Shared FIFO constants and width helpers, imported by the FIFO RTL, its
// interface and the protocol checkers.
package fifo_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DWIDTH = 16;

  // Pointer width: DEPTH is a power of two, so pointers wrap naturally.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit to represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DWIDTH register array: one synchronous write port and one registered
// read port. Only the read register is reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [DWIDTH-1:0]       wdata,
  input  logic                    re,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [DWIDTH-1:0]       rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; readers only see entries that
  // were written first, and a reset network on the array would be wasted.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty, drop-and-flag on illegal
// requests. Define SYNC_FIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DWIDTH = DEF_DWIDTH
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [DWIDTH-1:0]       din,
  input  logic                    rd_en,
  output logic [DWIDTH-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  ,
  output logic                    almost_full,
  output logic                    almost_empty
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance uses the registered flags, so no input reaches a flag
  // combinationally.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // NOTE: count_nxt gets a default before any conditional update so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      count     <= count_nxt;
      full      <= (count_nxt == CW'(DEPTH));
      empty     <= (count_nxt == '0);
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
    end
  end
`endif

  fifo_mem #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: table-driven vectors plus a data
// scoreboard, with hand-written wrap-around and asynchronous-reset sequences.
module tb_sync_fifo;

  localparam int DEPTH  = 8;
  localparam int DWIDTH = 16;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic              wr_en;
  logic              rd_en;
  logic [DWIDTH-1:0] din;
  logic [DWIDTH-1:0] dout;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DWIDTH (DWIDTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .din       (din),
    .rd_en     (rd_en),
    .dout      (dout),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] d;
    int          cnt;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  logic [15:0] exp_dout;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [15:0] d,
                     input int cnt, input logic ovf, input logic unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d = d; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  // One clock of stimulus; the scoreboard predicts data and flags from its
  // own queue occupancy, then outputs are sampled 1ns after the edge.
  task automatic step(input logic wr, input logic rd, input logic [15:0] d);
    logic e_ovf;
    logic e_unf;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    e_ovf = wr && (sb.size() == DEPTH);
    e_unf = rd && (sb.size() == 0);
    if (rd && sb.size() != 0) exp_dout = sb.pop_front();
    if (wr && !e_ovf) sb.push_back(d);
    @(posedge clk);
    #1;
    check("count", 32'(count), sb.size());
    check("full", 32'(full), 32'(sb.size() == DEPTH));
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("underflow", 32'(underflow), 32'(e_unf));
    check("dout", 32'(dout), 32'(exp_dout));
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    check("almost_full", 32'(almost_full), 32'(sb.size() >= DEPTH - 2));
    check("almost_empty", 32'(almost_empty), 32'(sb.size() <= 2));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Vector table: fill, overflow, drain, underflow, both-at-full, both-at-empty.
    add(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 16'(i), i, 1'b0, 1'b0);
    add(1'b1, 1'b0, 16'hDEAD, 8, 1'b1, 1'b0);
    add(1'b0, 1'b0, 16'h0000, 8, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) add(1'b0, 1'b1, 16'h0000, 8 - i, 1'b0, 1'b0);
    add(1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 16'(16'h0010 + i), i, 1'b0, 1'b0);
    add(1'b1, 1'b1, 16'hBEEF, 7, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, 16'h0000, 7 - i, 1'b0, 1'b0);
    add(1'b1, 1'b1, 16'hBEEF, 1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0);

    rstn     = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = '0;
    exp_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].d);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].unf));
    end
    check("beef_readback", 32'(dout), 32'h0000BEEF);

    // Steady occupancy of 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(16'h0100 + i));
    for (int i = 3; i < 23; i++) begin
      step(1'b1, 1'b1, 16'(16'h0100 + i));
      check("wrap_count", 32'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000);
    check("wrap_last", 32'(dout), 32'h00000116);

    // Asynchronous reset with five words buffered, away from any clock edge.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h0A00 + i));
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full", 32'(full), 32'd0);
    check("arst_dout", 32'(dout), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_underflow", 32'(underflow), 32'd0);
    sb.delete();
    exp_dout = '0;
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 16'h0000);
    check("post_rst_dout", 32'(dout), 32'h00001234);
    check("post_rst_count", 32'(count), 32'd0);

    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO. It buffers DWIDTH-bit words between one producer and one consumer through the team's fifo_if signal set.
- Drives full and empty, which producer/consumer logic and the protocol checkers observe.
- Never corrupts state on an illegal write-when-full or read-when-empty. Such requests are dropped and flagged for one cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- DWIDTH, 16, data word width in bits.
- AF_LEVEL, DEPTH-2, almost_full threshold (used only with the optional feature).
- AE_LEVEL, 2, almost_empty threshold (used only with the optional feature).

Ports:
- clk  input  1  single clock, all logic on its rising edge.
- rstn  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- din  input  DWIDTH  write data, sampled when a write is accepted.
- rd_en  input  1  read request.
- dout  output  DWIDTH  registered read data.
- full  output  1  count equals DEPTH.
- empty  output  1  count equals 0.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  one-cycle pulse: write dropped because full.
- underflow  output  1  one-cycle pulse: read dropped because empty.

Behaviour:
- Reset (rstn low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, dout=0, overflow=0, underflow=0. Memory contents are not reset.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en & !full
  - rd_acc = rd_en & !empty
- Write: on wr_acc, mem[wr_ptr] <= din and wr_ptr increments modulo DEPTH. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Read: on rd_acc, dout <= mem[rd_ptr] and rd_ptr increments modulo DEPTH.
  - Latency is 1 cycle: data is on dout in the cycle after rd_en is sampled.
  - dout holds its value when no read is accepted.
- Count:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both or neither are accepted
- full and empty are registered, derived from the next count. They are valid the same cycle count updates; there is no combinational path from inputs.
- Simultaneous wr_en and rd_en:
  - Full: read accepted, write dropped (overflow=1). Next state count=DEPTH-1, full=0.
  - Empty: write accepted, read dropped (underflow=1). No bypass; the written word is readable next cycle.
  - Otherwise: both accepted, count unchanged. A read of the entry being overwritten cannot occur, since rd_ptr != wr_ptr when not empty/full.
- overflow <= wr_en & full; underflow <= rd_en & empty. Each is high exactly one cycle per dropped request and is not sticky.
- Reset mid-operation: all state returns to reset values immediately. Buffered data is lost. The first accepted write after release lands at address 0.
- There is no state machine; state is pointers, count and registered flags.

Optional Feature:
- Macro: SYNC_FIFO_ALMOST_FLAGS_EN.
- Defined: adds two output ports, both registered from the next count:
  - almost_full: count >= AF_LEVEL
  - almost_empty: count <= AE_LEVEL
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: these ports and logic are absent; AF_LEVEL and AE_LEVEL are ignored.

Decomposition:
- fifo_pkg holds:
  - function ptr_w(depth) = $clog2(depth)
  - cnt_w = ptr_w+1
  - default DEPTH/DWIDTH constants, shared with the interface and checkers
- Sub-module fifo_mem: DEPTH x DWIDTH register array with one synchronous write port and one registered read port (we, waddr, wdata, re, raddr, rdata). It has no reset on storage. sync_fifo owns pointers, count and flags.

Test Plan (DEPTH=8, DWIDTH=16):
- Reset release, no activity -> empty=1, full=0, count=0, dout=0; overflow and underflow stay 0.
- Write 0x0001..0x0008 on 8 consecutive cycles -> full=1 the cycle after the 8th write, count=8. A 9th write of 0xDEAD -> overflow pulses 1 cycle, count stays 8. Then 8 reads -> dout sequence 0x0001..0x0008, each one cycle after its rd_en, empty=1 after the last.
- Read while empty -> underflow pulses 1 cycle, dout unchanged, count=0.
- Fill to 8, then wr_en=rd_en=1 with din=0xBEEF -> read of the oldest word accepted, write dropped, overflow=1, count=7. At count=0 with both asserted -> write accepted, underflow=1, count=1, next read returns 0xBEEF.
- Wrap-around: 20 cycles of concurrent write/read at steady occupancy 3 with incrementing data -> dout strictly in order across pointer wrap, count constant at 3.
- Assert rstn low with count=5 -> all outputs to reset values asynchronously. After release, write 0x1234 and read it -> dout=0x1234, count returns to 0.
- With SYNC_FIFO_ALMOST_FLAGS_EN: almost_full rises at count=6; almost_empty falls at count=3.
